rip_wb_sched: RTL and testbench

Write-port scheduler and scoreboard for the integer register file. It shares the register file's single write port between two sources. The first is the in-order memory-access (MA) writeback stage, which has fixed priority and no backpressure. The second is a single-outstanding multicycle unit (divider/CSR-class), served through a valid/ready handshake and a one-entry hold buffer. It also tracks the multicycle unit's pending destination register and raises an issue stall on RAW, WAW or structural conflicts. It sits between the MA/multicycle stages and the register file write port, and feeds the IF/ID stall logic.

---
 rtl/rip_wb_sched.sv | 109 ++++++++++
 tb/tb_rip_wb_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rip_wb_sched.sv
// Register-file write-port scheduler: MA writeback has fixed priority, a single
// outstanding multicycle result is merged through a one-entry hold buffer.
module rip_wb_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        ma_wen,
   input  logic [4:0]  ma_rd_num,
   input  logic [31:0] ma_wdata,
   input  logic        mc_issue,
   input  logic [4:0]  mc_issue_rd,
   input  logic        mc_flush,
   input  logic        mc_valid,
   input  logic [31:0] mc_wdata,
   output logic        mc_ready,
   input  logic [4:0]  if_rs1_num,
   input  logic [4:0]  if_rs2_num,
   input  logic [4:0]  if_rd_num,
   input  logic        if_is_mc,
   output logic        stall,
   output logic        rf_wen,
   output logic [4:0]  rf_rd_num,
   output logic [31:0] rf_wdata,
   output logic        issue_err
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [4:0]  r_pend_rd;
   logic [31:0] r_buf_data;
   logic        r_issue_err;

   logic w_busy;
   logic w_xfer;
   logic w_conflict;
   logic w_pend_nz;

   always_comb begin
      w_next    = r_state;
      w_busy    = (r_state != ST_IDLE);
      mc_ready  = (r_state == ST_PENDING);
      w_xfer    = mc_ready && mc_valid;
      w_pend_nz = (r_pend_rd != 5'd0);
      unique case (r_state)
         ST_IDLE:    if (mc_issue) w_next = ST_PENDING;
         // flush wins over a same-cycle result, which is then discarded
         ST_PENDING: if (mc_flush)     w_next = ST_IDLE;
                     else if (w_xfer)  w_next = ma_wen ? ST_HOLD : ST_IDLE;
         ST_HOLD:    if (!ma_wen)      w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_conflict = w_pend_nz && ((r_pend_rd == if_rs1_num) ||
                                 (r_pend_rd == if_rs2_num) ||
                                 (r_pend_rd == if_rd_num));
      stall      = w_busy && (w_conflict || if_is_mc);
   end

   // Writes to x0 from the multicycle path are dropped entirely
   always_comb begin
      rf_wen    = 1'b0;
      rf_rd_num = '0;
      rf_wdata  = '0;
      if (ma_wen) begin
         rf_wen    = 1'b1;
         rf_rd_num = ma_rd_num;
         rf_wdata  = ma_wdata;
      end else if (r_state == ST_HOLD) begin
         if (w_pend_nz) begin
            rf_wen    = 1'b1;
            rf_rd_num = r_pend_rd;
            rf_wdata  = r_buf_data;
         end
      end else if (w_xfer && !mc_flush) begin
         if (w_pend_nz) begin
            rf_wen    = 1'b1;
            rf_rd_num = r_pend_rd;
            rf_wdata  = mc_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_pend_rd   <= '0;
         r_buf_data  <= '0;
         r_issue_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (!w_busy && mc_issue)
            r_pend_rd <= mc_issue_rd;
         if (w_xfer && !mc_flush && ma_wen)
            r_buf_data <= mc_wdata;
         if (w_busy && mc_issue)
            r_issue_err <= 1'b1;
      end
   end

   assign issue_err = r_issue_err;

endmodule

// File: tb/tb_rip_wb_sched.sv
// Scoreboard bench for rip_wb_sched: a queue-based reference model predicts each
// cycle's outputs, a negedge monitor pops and compares.
module tb_rip_wb_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        ma_wen;
   logic [4:0]  ma_rd_num;
   logic [31:0] ma_wdata;
   logic        mc_issue;
   logic [4:0]  mc_issue_rd;
   logic        mc_flush;
   logic        mc_valid;
   logic [31:0] mc_wdata;
   logic        mc_ready;
   logic [4:0]  if_rs1_num;
   logic [4:0]  if_rs2_num;
   logic [4:0]  if_rd_num;
   logic        if_is_mc;
   logic        stall;
   logic        rf_wen;
   logic [4:0]  rf_rd_num;
   logic [31:0] rf_wdata;
   logic        issue_err;

   rip_wb_sched dut (
      .clk(clk), .rst(rst),
      .ma_wen(ma_wen), .ma_rd_num(ma_rd_num), .ma_wdata(ma_wdata),
      .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd), .mc_flush(mc_flush),
      .mc_valid(mc_valid), .mc_wdata(mc_wdata), .mc_ready(mc_ready),
      .if_rs1_num(if_rs1_num), .if_rs2_num(if_rs2_num), .if_rd_num(if_rd_num),
      .if_is_mc(if_is_mc), .stall(stall),
      .rf_wen(rf_wen), .rf_rd_num(rf_rd_num), .rf_wdata(rf_wdata),
      .issue_err(issue_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        wen;
      bit [4:0]  rd;
      bit [31:0] data;
      bit        zchk;
      bit        ready;
      bit        stall;
      bit        err;
   } exp_t;

   // Outstanding multicycle op: destination, and the result once captured
   typedef struct {
      bit [4:0]  rd;
      bit        got;
      bit [31:0] data;
   } op_t;

   exp_t exp_q[$];
   op_t  m_ops[$];
   bit   m_err;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s at %0t: got=0x%0h expected=0x%0h", name, $time, act, want);
      end
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("rf_wen", {31'd0, rf_wen}, {31'd0, mon_e.wen});
         if (mon_e.wen || mon_e.zchk) begin
            check("rf_rd_num", {27'd0, rf_rd_num}, {27'd0, mon_e.rd});
            check("rf_wdata", rf_wdata, mon_e.data);
         end
         check("mc_ready", {31'd0, mc_ready}, {31'd0, mon_e.ready});
         check("stall", {31'd0, stall}, {31'd0, mon_e.stall});
         check("issue_err", {31'd0, issue_err}, {31'd0, mon_e.err});
      end
   end

   // Predict this cycle's outputs from current inputs, then advance the model
   task automatic cyc(input bit chk);
      exp_t     e;
      bit       busy, has, ready, xfer;
      bit [4:0] prd;
      busy  = (m_ops.size() != 0);
      has   = busy && m_ops[0].got;
      ready = busy && !has;
      xfer  = ready && mc_valid;
      prd   = busy ? m_ops[0].rd : 5'd0;
      e = '{wen: 1'b0, rd: 5'd0, data: 32'd0, zchk: 1'b1,
            ready: ready, stall: 1'b0, err: m_err};
      e.stall = busy && (if_is_mc || (prd != 0 &&
                (prd == if_rs1_num || prd == if_rs2_num || prd == if_rd_num)));
      if (ma_wen) begin
         e.wen = 1'b1; e.rd = ma_rd_num; e.data = ma_wdata;
      end else if (has || (xfer && !mc_flush)) begin
         if (prd != 0) begin
            e.wen = 1'b1; e.rd = prd; e.data = has ? m_ops[0].data : mc_wdata;
         end else
            e.zchk = 1'b0;
      end
      if (chk) exp_q.push_back(e);
      if (rst) begin
         m_ops.delete();
         m_err = 1'b0;
      end else begin
         if (mc_issue && busy) m_err = 1'b1;
         if (has) begin
            if (!ma_wen) void'(m_ops.pop_front());
         end else if (ready && mc_flush) begin
            void'(m_ops.pop_front());
         end else if (xfer) begin
            if (ma_wen) begin
               m_ops[0].got = 1'b1;
               m_ops[0].data = mc_wdata;
            end else
               void'(m_ops.pop_front());
         end
         if (mc_issue && !busy) m_ops.push_back('{rd: mc_issue_rd, got: 1'b0, data: 32'd0});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      ma_wen = 0; ma_rd_num = 0; ma_wdata = 0;
      mc_issue = 0; mc_issue_rd = 0; mc_flush = 0; mc_valid = 0; mc_wdata = 0;
      if_rs1_num = 0; if_rs2_num = 0; if_rd_num = 0; if_is_mc = 0;
   endtask

   task automatic issue(input logic [4:0] rd);
      clr(); mc_issue = 1; mc_issue_rd = rd; cyc(1); clr();
   endtask

   initial begin
      rst = 1; clr();
      @(posedge clk); #1;
      cyc(0); cyc(1);
      rst = 0;
      ma_wen = 1; ma_rd_num = 5; ma_wdata = 32'h1234; cyc(1); clr();

      // direct writeback
      issue(7); if_rs1_num = 7; cyc(1);
      mc_valid = 1; mc_wdata = 32'hDEADBEEF; cyc(1);
      mc_valid = 0; cyc(1);

      // port contention
      issue(9); if_rs2_num = 9;
      mc_valid = 1; mc_wdata = 32'hCAFE; ma_wen = 1; ma_rd_num = 2; ma_wdata = 32'h11; cyc(1);
      mc_valid = 0; ma_rd_num = 9; ma_wdata = 32'h22; cyc(1); cyc(1);
      ma_wen = 0; cyc(1); cyc(1); clr();

      // flush with same-cycle result, then flush while holding
      issue(3); mc_flush = 1; mc_valid = 1; mc_wdata = 32'h55; cyc(1);
      clr(); if_rs1_num = 3; cyc(1);
      issue(4); mc_valid = 1; mc_wdata = 32'h77; ma_wen = 1; ma_rd_num = 1; cyc(1);
      mc_valid = 0; mc_flush = 1; cyc(1);
      ma_wen = 0; cyc(1); clr(); cyc(1);

      // rd = 0, structural stall, double issue
      issue(0); if_rs1_num = 0; cyc(1);
      if_is_mc = 1; cyc(1);
      if_is_mc = 0; mc_issue = 1; mc_issue_rd = 6; if_rd_num = 6; cyc(1);
      clr(); mc_valid = 1; mc_wdata = 32'h99; cyc(1);
      clr(); cyc(1);

      // reset while holding
      issue(8); mc_valid = 1; mc_wdata = 32'hBEEF; ma_wen = 1; ma_rd_num = 2; cyc(1);
      mc_valid = 0; rst = 1; cyc(1);
      rst = 0; clr(); cyc(1); cyc(1);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         rst         = ($urandom_range(0, 99) == 0);
         ma_wen      = $urandom_range(0, 1);
         ma_rd_num   = 5'($urandom_range(0, 31));
         ma_wdata    = $urandom;
         mc_issue    = ($urandom_range(0, 5) == 0);
         mc_issue_rd = 5'($urandom_range(0, 7));
         mc_flush    = ($urandom_range(0, 15) == 0);
         mc_valid    = ($urandom_range(0, 2) == 0);
         mc_wdata    = $urandom;
         if_rs1_num  = 5'($urandom_range(0, 7));
         if_rs2_num  = 5'($urandom_range(0, 7));
         if_rd_num   = 5'($urandom_range(0, 7));
         if_is_mc    = ($urandom_range(0, 3) == 0);
         cyc(1);
      end
      rst = 0; clr(); cyc(1);
      @(negedge clk); #1;
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
